// File: rtl/mc_rfr_exec.sv
// mc_rfr_exec: refresh executor for the SDRAM memory controller.
//
// Answers the refresh timer's rfr_req/rfr_ack handshake. For each request it
// takes the SDRAM command bus, closes open rows with PRECHARGE-ALL, issues a
// programmable burst of AUTO-REFRESH commands while honouring tRP/tRFC, then
// acknowledges the request and releases the bus.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   rfr_req / rfr_ack    refresh request (level) / one-cycle acknowledge
//   cs_need_rfr          chip selects that need refresh (latched at grant)
//   bank_open            per-CS "any row open" flags (latched at grant)
//   trp, trfc            precharge / refresh waits in cycles (sampled at load)
//   rfr_burst            number of AUTO-REFRESH commands minus one
//   bus_req / bus_gnt    command-bus request / grant
//   cs_n, ras_n, cas_n,
//   we_n, a10            registered SDRAM command
//   bank_clr             one-cycle pulse per precharged CS
//   rfr_busy             high whenever the executor is not idle
module mc_rfr_exec #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rfr_req,
    output logic          rfr_ack,
    input  logic [7:0]    cs_need_rfr,
    input  logic [7:0]    bank_open,
    input  logic [CW-1:0] trp,
    input  logic [CW-1:0] trfc,
    input  logic [2:0]    rfr_burst,
    output logic          bus_req,
    input  logic          bus_gnt,
    output logic [7:0]    cs_n,
    output logic          ras_n,
    output logic          cas_n,
    output logic          we_n,
    output logic          a10,
    output logic [7:0]    bank_clr,
    output logic          rfr_busy
);

    typedef enum logic [2:0] {
        IDLE, ARB, PRE, TRP, REF, TRFC, ACK
    } state_e;

    state_e        state_q, state_d;
    logic [7:0]    need_q, need_d;    // chip selects to refresh
    logic [7:0]    open_q, open_d;    // chip selects to precharge
    logic [2:0]    burst_q, burst_d;  // refreshes minus one for this request
    logic [2:0]    bcnt_q, bcnt_d;    // refreshes already issued minus one
    logic [CW-1:0] wcnt_q, wcnt_d;    // tRP / tRFC countdown
    logic          last_q, last_d;    // final refresh issued; next expiry acks
    logic          ign_q;             // ignore rfr_req the cycle after ACK

    // Next-state logic. Outputs are decoded from state_d in the register
    // block so every command appears on the pins the cycle the state is entered.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_d = state_q;
        need_d  = need_q;
        open_d  = open_q;
        burst_d = burst_q;
        bcnt_d  = bcnt_q;
        wcnt_d  = wcnt_q;
        last_d  = last_q;

        case (state_q)
            IDLE: begin
                if (rfr_req && !ign_q) state_d = ARB;
            end
            ARB: begin
                if (bus_gnt) begin
                    need_d  = cs_need_rfr;
                    open_d  = bank_open & cs_need_rfr;
                    burst_d = rfr_burst;
                    if (cs_need_rfr == 8'h00)                   state_d = ACK;
                    else if ((bank_open & cs_need_rfr) != 8'h00) state_d = PRE;
                    else                                         state_d = REF;
                end
            end
            PRE: begin
                if (trp != '0) begin
                    state_d = TRP;
                    wcnt_d  = trp;
                end else begin
                    state_d = REF;
                end
            end
            TRP: begin
                wcnt_d = wcnt_q - CW'(1);
                if (wcnt_q == CW'(1)) state_d = REF;
            end
            REF: begin
                if (bcnt_q < burst_q) begin
                    bcnt_d = bcnt_q + 3'd1;
                end else begin
                    last_d = 1'b1;
                end
                // The final refresh still waits out tRFC before the ack.
                if (trfc != '0) begin
                    state_d = TRFC;
                    wcnt_d  = trfc;
                end else if (bcnt_q < burst_q) begin
                    state_d = REF;
                end else begin
                    state_d = ACK;
                end
            end
            TRFC: begin
                wcnt_d = wcnt_q - CW'(1);
                if (wcnt_q == CW'(1)) state_d = last_q ? ACK : REF;
            end
            ACK: begin
                state_d = IDLE;
                bcnt_d  = 3'd0;
                last_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, latched request data and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            need_q   <= 8'h00;
            open_q   <= 8'h00;
            burst_q  <= 3'd0;
            bcnt_q   <= 3'd0;
            wcnt_q   <= '0;
            last_q   <= 1'b0;
            ign_q    <= 1'b0;
            bus_req  <= 1'b0;
            rfr_ack  <= 1'b0;
            rfr_busy <= 1'b0;
            cs_n     <= 8'hFF;
            ras_n    <= 1'b1;
            cas_n    <= 1'b1;
            we_n     <= 1'b1;
            a10      <= 1'b0;
            bank_clr <= 8'h00;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values and evaluation order inside the block is moot.
            state_q  <= state_d;
            need_q   <= need_d;
            open_q   <= open_d;
            burst_q  <= burst_d;
            bcnt_q   <= bcnt_d;
            wcnt_q   <= wcnt_d;
            last_q   <= last_d;
            ign_q    <= (state_q == ACK);
            bus_req  <= (state_d inside {ARB, PRE, TRP, REF, TRFC});
            rfr_ack  <= (state_d == ACK);
            rfr_busy <= (state_d != IDLE);

            // NOP unless the next state drives a command.
            cs_n     <= 8'hFF;
            ras_n    <= 1'b1;
            cas_n    <= 1'b1;
            we_n     <= 1'b1;
            a10      <= 1'b0;
            bank_clr <= 8'h00;
            case (state_d)
                PRE: begin
                    cs_n     <= ~open_d;
                    ras_n    <= 1'b0;
                    we_n     <= 1'b0;
                    a10      <= 1'b1;
                    bank_clr <= open_d;
                end
                REF: begin
                    cs_n  <= ~need_d;
                    ras_n <= 1'b0;
                    cas_n <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
